// File: rtl/multicycle_ctrl.sv
// Multi-cycle control path: FETCH/DECODE/EXECUTE/MEM/WB against req/ack memories, sticky HALT on fault.
// Latency (zero-wait): nop 3, ALU 4, store 4, load 5 cycles; requests hold until ack or timeout.
module multicycle_ctrl #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           ILEN_BYTES  = 4,
  parameter int unsigned           MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_ack,
  output logic [DATA_WIDTH-1:0] instr,
  input  logic                  dec_reg_write,
  input  logic                  dec_mem_read,
  input  logic                  dec_mem_write,
  input  logic                  dec_use_imm,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  rd_we,
  output logic [DATA_WIDTH-1:0] rd_wdata,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [2:0]            state,
  output logic                  retire,
  output logic                  fault
);

  localparam int unsigned           WCW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0]        TMO    = WCW'(MEM_TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] PC_INC = DATA_WIDTH'(ILEN_BYTES);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [DATA_WIDTH-1:0] aluout_q, aluout_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic [WCW-1:0]        wait_q, wait_d;
  logic                  fault_q, fault_d;
  logic [WCW-1:0]        wait_inc;
  logic                  timeout_hit;
  logic                  illegal;
  logic                  retire_c;

  assign wait_inc    = wait_q + WCW'(1);
  // The cycle that would make the wait count reach the limit is the last one allowed.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_inc == TMO);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    wait_d   = wait_q;
    fault_d  = fault_q;
    retire_c = 1'b0;
    illegal  = (dec_mem_read && dec_mem_write) || (dec_mem_write && dec_reg_write);

    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DECODE: begin
        a_d     = rs1_data;
        b_d     = rs2_data;
        imm_d   = imm;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        aluout_d = alu_result;
        if (illegal) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else if (dec_mem_read || dec_mem_write) begin
          wait_d  = '0;
          state_d = S_MEM;
        end else if (dec_reg_write) begin
          state_d = S_WB;
        end else begin
          retire_c = 1'b1;
          pc_d     = pc_q + PC_INC;
          wait_d   = '0;
          state_d  = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (dec_mem_write) begin
            retire_c = 1'b1;
            pc_d     = pc_q + PC_INC;
            wait_d   = '0;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_WB: begin
        retire_c = 1'b1;
        pc_d     = pc_q + PC_INC;
        wait_d   = '0;
        state_d  = S_FETCH;
      end
      S_HALT: begin
      end
      default: begin
        fault_d = 1'b1;
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      wait_q   <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      wait_q   <= wait_d;
      fault_q  <= fault_d;
    end
  end

  // Reset parks the FSM in FETCH, so only the fetch request needs masking by rst_n.
  assign imem_req   = rst_n && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign instr      = instr_q;
  assign alu_a      = a_q;
  assign alu_b      = dec_use_imm ? imm_q : b_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_req && dec_mem_write;
  assign dmem_addr  = aluout_q;
  assign dmem_wdata = b_q;
  assign rd_we      = (state_q == S_WB);
  assign rd_wdata   = dec_mem_read ? mdr_q : aluout_q;
  assign pc         = pc_q;
  assign state      = state_q;
  assign retire     = retire_c;
  assign fault      = fault_q;

endmodule
